// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared encodings and default latencies for the md scheduler
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multi-cycle mult/div scheduler owning HI/LO and the md stall request
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_md
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa, sb, quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;
  logic               div_ovf, div_zero;

  always_comb begin
    sa       = $signed(src_a);
    sb       = $signed(src_b);
    prod_s   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    prod_u   = {32'd0, src_a} * {32'd0, src_b};
    div_zero = (src_b == 32'd0);
    div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    // Guard the divider operands so the zero and overflow cases never reach it.
    quot_s   = (div_zero || div_ovf) ? 32'sd0 : sa / sb;
    rem_s    = (div_zero || div_ovf) ? 32'sd0 : sa % sb;
    quot_u   = div_zero ? 32'd0 : src_a / src_b;
    rem_u    = div_zero ? 32'd0 : src_a % src_b;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              pend_hi_d = (md_op == MD_MULT) ? prod_s[63:32] : prod_u[63:32];
              pend_lo_d = (md_op == MD_MULT) ? prod_s[31:0]  : prod_u[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = 4'(MULT_CYCLES);
              state_d   = ST_RUN;
            end
            MD_DIV: begin
              pend_hi_d = div_ovf ? 32'd0 : rem_s;
              pend_lo_d = div_ovf ? 32'h8000_0000 : quot_s;
              pend_wr_d = !div_zero;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            MD_DIVU: begin
              pend_hi_d = rem_u;
              pend_lo_d = quot_u;
              pend_wr_d = !div_zero;
              cnt_d     = 4'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q <= 4'd1) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall_md = md_use_D & (busy | (start & is_muldiv(md_op)));

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed self-checking bench for md_sched
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        md_use_D = 1'b0;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2,
                         OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

  md_sched dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .md_use_D(md_use_D),
    .busy(busy), .hi(hi), .lo(lo), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  // Protocol check: the hazard unit must never issue start while busy.
  always @(negedge clk) begin
    if (busy && !reset) begin
      checks++;
      if (start) begin
        errors++;
        $display("FAIL start_while_busy: start=%0b required 0", start);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cnt = 0;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    step();
    start = 1'b0; md_op = OP_NONE;
    while (busy && cnt < 40) begin
      cnt++;
      step();
    end
    checks++;
    if (cnt !== n) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", name, cnt, n);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s_result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h stall=%b required 0/0/0/0", busy, hi, lo, stall_md);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mult();
    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
  endtask

  task automatic test_div();
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_hazard();
    int stalled = 0;
    int busy_cnt = 0;
    int stray = 0;
    md_use_D = 1'b1;
    start = 1'b1; md_op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    #1;
    checks++;
    if (stall_md !== 1'b1) begin
      errors++;
      $display("FAIL hazard_start_stall: got %b required 1", stall_md);
    end
    step();
    start = 1'b0; md_op = OP_NONE;
    while (busy && busy_cnt < 40) begin
      busy_cnt++;
      if (stall_md === 1'b1) stalled++;
      step();
    end
    checks++;
    if (stalled !== 10) begin
      errors++;
      $display("FAIL hazard_busy_stall: stalled %0d cycles required 10", stalled);
    end
    checks++;
    if (stall_md !== 1'b0) begin
      errors++;
      $display("FAIL hazard_after_stall: got %b required 0", stall_md);
    end
    md_use_D = 1'b0;
    start = 1'b1; md_op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    #1;
    if (stall_md !== 1'b0) stray++;
    step();
    start = 1'b0; md_op = OP_NONE;
    for (int i = 0; i < 12; i++) begin
      if (stall_md !== 1'b0) stray++;
      step();
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL hazard_no_use: stalled %0d cycles required 0", stray);
    end
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; md_op = OP_MTHI; src_a = 32'h1234_5678;
    step();
    md_op = OP_MTLO; src_a = 32'hCAFE_BABE;
    checks++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h busy=%b required hi=12345678 busy=0", hi, busy);
    end
    step();
    start = 1'b0; md_op = OP_NONE;
    checks++;
    if (lo !== 32'hCAFE_BABE || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b required 12345678/cafebabe/0", hi, lo, busy);
    end
    run_op("divzero", OP_DIV, 32'd99, 32'd0, 10, 32'h1234_5678, 32'hCAFE_BABE);
    run_op("divuzero", OP_DIVU, 32'd99, 32'd0, 10, 32'h1234_5678, 32'hCAFE_BABE);
  endtask

  task automatic test_undefined_op();
    start = 1'b1; md_op = 3'd7; src_a = 32'hDEAD_BEEF; src_b = 32'd5;
    step();
    start = 1'b0; md_op = OP_NONE;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL undefined_op: busy=%b hi=%h lo=%h required 0/12345678/cafebabe", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen42 = 0;
    start = 1'b1; md_op = OP_MULT; src_a = 32'd6; src_b = 32'd7;
    step();
    start = 1'b0; md_op = OP_NONE;
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: got %b required 1", busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    for (int i = 0; i < 10; i++) begin
      if (lo === 32'd42) seen42++;
      step();
    end
    checks++;
    if (seen42 !== 0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL abort_discard: lo=%h seen42=%0d required lo=0 seen42=0", lo, seen42);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_hazard();
    test_mthi_mtlo();
    test_undefined_op();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
